pe_cluster_sched: RTL

//  Job sequencer for the 8x8 PE cluster (pe_8x8_cluster).
//  - Accepts one matmul job (depth K) per start handshake.
//  - Fetches K operand slices, skews them per row, drives the cluster activation/weight buses.
//  - Raises per-row input-done, waits for all 64 PE output-dones, then presents results

---
 rtl/pe_cluster_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/pe_cluster_sched.sv
// Job sequencer for the 8x8 PE cluster: streams K operand slices through a triangular skew,
// waits for every PE output-done, then hands the held results off via valid/ready.
module pe_cluster_sched #(
  parameter int unsigned LANES   = 8,
  parameter int unsigned DW      = 16,
  parameter int unsigned KW      = 5,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_valid_i,
  output logic                     start_ready_o,
  input  logic [KW-1:0]            start_k_i,
  output logic [KW-1:0]            src_k_o,
  input  logic [LANES*DW-1:0]      src_a_i,
  input  logic [LANES*DW-1:0]      src_b_i,
  output logic [LANES*DW-1:0]      cl_act_o,
  output logic [LANES*DW-1:0]      cl_wgt_o,
  output logic                     cl_rst_n_o,
  output logic [LANES-1:0]         cl_row_done_o,
  input  logic [LANES*LANES-1:0]   cl_out_done_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     res_err_o,
  output logic                     busy_o
);

  localparam int unsigned KMax = 16;
  localparam int unsigned DcW  = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StClr, StFeed, StDrain, StResult} state_e;

  state_e state_q, state_d;

  logic [KW-1:0]       k_q, k_d;
  logic [KW-1:0]       t_q, t_d;
  logic [DcW-1:0]      dcnt_q, dcnt_d;
  logic                res_err_q, res_err_d;
  logic                cl_rst_n_q, cl_rst_n_d;
  logic [LANES-1:0]    row_done_q, row_done_d, row_hit;
  logic [LANES*DW-1:0] act_q, act_d, wgt_q, wgt_d;
  logic [LANES*DW-1:0] skew_a, skew_b;
  logic                k_bad, feed_live, all_out_done, drain_last;

  assign k_bad        = (start_k_i == '0) || (start_k_i > KW'(KMax));
  assign feed_live    = (state_q == StFeed) && (t_q < k_q);
  assign all_out_done = &cl_out_done_i;
  assign drain_last   = (dcnt_q == DcW'(TIMEOUT - 1));

  // Row r is delayed by r register stages, giving the diagonal wavefront the array expects.
  for (genvar r = 0; r < LANES; r++) begin : g_row
    logic [DW-1:0] a_in, b_in;
    assign a_in = feed_live ? src_a_i[r*DW +: DW] : '0;
    assign b_in = feed_live ? src_b_i[r*DW +: DW] : '0;
    // Last slice of row r reaches the skew output in FEED cycle K-1+r.
    assign row_hit[r] = (state_q == StFeed) && ((t_q + KW'(1)) == (k_q + KW'(r)));

    if (r == 0) begin : g_direct
      assign skew_a[DW-1:0] = a_in;
      assign skew_b[DW-1:0] = b_in;
    end else begin : g_delay
      logic [DW-1:0] a_dly_q [r];
      logic [DW-1:0] b_dly_q [r];

      always_ff @(posedge clk_i) begin
        if (rst_i || (state_q != StFeed)) begin
          for (int i = 0; i < r; i++) begin
            a_dly_q[i] <= '0;
            b_dly_q[i] <= '0;
          end
        end else begin
          a_dly_q[0] <= a_in;
          b_dly_q[0] <= b_in;
          for (int i = 1; i < r; i++) begin
            a_dly_q[i] <= a_dly_q[i-1];
            b_dly_q[i] <= b_dly_q[i-1];
          end
        end
      end

      assign skew_a[r*DW +: DW] = a_dly_q[r-1];
      assign skew_b[r*DW +: DW] = b_dly_q[r-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start_valid_i) state_d = k_bad ? StResult : StClr;
      StClr:    state_d = StFeed;
      StFeed:   if (&(row_done_q | row_hit)) state_d = StDrain;
      StDrain:  if (all_out_done || drain_last) state_d = StResult;
      StResult: if (res_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    start_ready_o = (state_q == StIdle) && !rst_i;
    busy_o        = (state_q != StIdle);
    res_valid_o   = (state_q == StResult);
    src_k_o       = '0;
    if (state_q == StFeed) begin
      src_k_o = (t_q < k_q) ? t_q : (k_q - KW'(1));
    end
  end

  always_comb begin
    k_d       = k_q;
    t_d       = '0;
    dcnt_d    = '0;
    res_err_d = res_err_q;
    if (state_q == StIdle && start_valid_i) begin
      k_d       = start_k_i;
      res_err_d = k_bad;
    end
    if (state_q == StFeed) t_d = t_q + KW'(1);
    if (state_q == StDrain) begin
      dcnt_d = dcnt_q + DcW'(1);
      if (!all_out_done && drain_last) res_err_d = 1'b1;
    end
    if (state_q == StResult && res_ready_i) res_err_d = 1'b0;

    cl_rst_n_d = (state_d == StFeed) || (state_d == StDrain) || (state_d == StResult);

    // Row dones are sticky for the whole job and drop together with the cluster reset.
    row_done_d = row_done_q | row_hit;
    if ((state_q == StIdle) || (state_q == StClr) || (state_q == StResult && res_ready_i)) begin
      row_done_d = '0;
    end

    act_d = (state_q == StFeed) ? skew_a : '0;
    wgt_d = (state_q == StFeed) ? skew_b : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q        <= '0;
      t_q        <= '0;
      dcnt_q     <= '0;
      res_err_q  <= 1'b0;
      cl_rst_n_q <= 1'b0;
      row_done_q <= '0;
      act_q      <= '0;
      wgt_q      <= '0;
    end else begin
      k_q        <= k_d;
      t_q        <= t_d;
      dcnt_q     <= dcnt_d;
      res_err_q  <= res_err_d;
      cl_rst_n_q <= cl_rst_n_d;
      row_done_q <= row_done_d;
      act_q      <= act_d;
      wgt_q      <= wgt_d;
    end
  end

  assign cl_act_o      = act_q;
  assign cl_wgt_o      = wgt_q;
  assign cl_rst_n_o    = cl_rst_n_q;
  assign cl_row_done_o = row_done_q;
  assign res_err_o     = res_err_q;

endmodule
